rx_iq_formatter: RTL and testbench
==================================

// Module: rx_iq_formatter
// PURPOSE
//  Sits directly upstream of the I2S slave transmitter in the DDC receive path.
//  - Takes full-precision DDC I/Q samples and applies a programmable power-of-2 gain.
//  - Rounds and saturates each sample to 24 bits, then buffers it in a small FIFO.
//  - Presents the result on hold registers that change exactly once per audio frame.
//  - Between updates the outputs are quasi-static, so the I2S block's per-bit cdc_sync sampling is safe.
// PARAMETERS
//  IN_W        32    DDC sample width (signed, two's complement)
//  OUT_W       24    output sample width; IN_W-OUT_W >= 1
//  FIFO_AW     2     FIFO address width; depth = 2**FIFO_AW
//  PACE_DIV    2560  clock cycles per output update (122.88 MHz / 48 kHz); >= 4
// PORTS
//  clock       in   1       system clock, single domain
//  reset       in   1       asynchronous, active-low reset
//  gain_shift  in   4       left shift 0..15 applied before rounding
//  clr_flags   in   1       1-cycle pulse, clears overrun/underrun
//  in_valid    in   1       in_real/in_imag valid this cycle; no backpressure
//  in_real     in   IN_W    DDC I sample
//  in_imag     in   IN_W    DDC Q sample
//  out_real    out  OUT_W   held I sample, to I2S _rx_real
//  out_imag    out  OUT_W   held Q sample, to I2S _rx_imag
//  out_stb     out  1       1-cycle pulse in the cycle after out_* change
//  fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
//  overrun     out  1       sticky: a sample was dropped because the FIFO was full
//  underrun    out  1       sticky: a tick found the FIFO empty
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFO empty, pace counter 0, pipeline valids 0.
//  Datapath, per channel, 2 registered stages; I and Q are always handled as a pair.
//   S1: ext = sign-extend in to IN_W+16; sh = ext <<< gain_shift.
//       r = sh + 2**(IN_W-OUT_W-1), i.e. round half up.
//   S2: q = r >>> (IN_W-OUT_W).
//       Saturate q to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
//       Push {q_real,q_imag} into the FIFO.
//   Latency: in_valid at cycle n -> FIFO write at the edge ending cycle n+2.
//   gain_shift is sampled in S1; a change affects samples entering S1 from the next edge on.
//  Pacer: counter runs 0..PACE_DIV-1 and wraps; tick = (count == PACE_DIV-1).
//   On tick with FIFO non-empty: pop into out_real/out_imag; out_stb=1 next cycle.
//   On tick with FIFO empty: outputs hold their value; underrun <= 1; out_stb stays 0.
//  FIFO: a push when full (and no pop that cycle) drops the sample; overrun <= 1.
//   Simultaneous push+pop when full: the pop frees a slot and the push is accepted; level unchanged.
//   Simultaneous push+tick when empty: underrun is flagged and the push is stored; no bypass path.
//   Pointers wrap modulo 2**FIFO_AW; full/empty are derived from the extra pointer bit.
//  Flags: clr_flags clears both; a new event in the same cycle wins (flag reads 1).
//  Reset mid-stream: in-flight and buffered samples are discarded; outputs return to 0.
// CONFIGURATION
//  RX_TEST_PATTERN_EN defined:
//   - Adds input port test_mode (1 bit, placed after clr_flags).
//   - When test_mode=1, each tick loads out_real = 24-bit ramp counter, out_imag = ~ramp.
//   - The ramp starts at 0 after reset and increments per tick.
//   - The FIFO still pops on each tick, but no underrun is flagged while test_mode=1.
//  Undefined: the test_mode port and ramp logic are absent; normal behaviour only.
// STRUCTURE
//  Package rx_iq_pkg: IN_W/OUT_W defaults, ROUND_BIAS, SAT_MAX/SAT_MIN constants, iq_pair_t {real,imag}.
//  Sub-module rx_iq_fifo: synchronous FIFO, one clock, (2*OUT_W)-bit word, push/pop/level/full/empty.
//  Top level holds the S1/S2 pipeline, the pacer, the output registers and the flags.
// TESTING (IN_W=32, OUT_W=24, FIFO_AW=2, PACE_DIV=8)
//  1. gain 0, in_real=32'h0000_1280, in_imag=32'hFFFF_FE80 -> next pop gives out_real=24'h000013, out_imag=24'hFFFFFF; out_stb 1 cycle.
//  2. gain 1, in_real=32'h4000_0000, in_imag=32'h8000_0000 -> out_real=24'h7FFFFF, out_imag=24'h800000 (both saturated).
//  3. in_valid held high for 20 cycles -> fifo_level reaches 4, overrun=1; the popped sequence equals the first 4 inputs plus those accepted on pop slots.
//  4. No input after reset -> first tick at cycle 8: underrun=1, out_*=0, no out_stb; clr_flags -> 0; clr_flags coincident with an underrun tick -> stays 1.
//  5. Assert reset with 3 samples buffered -> fifo_level=0, out_*=0, flags 0 immediately; the first tick after release underruns.
//  6. RX_TEST_PATTERN_EN with test_mode=1 -> successive ticks give out_real 0,1,2,..., out_imag FFFFFF,FFFFFE,...; underrun stays 0.

Source files
------------

// File: rtl/rx_iq_pkg.sv
// rx_iq_pkg: shared constants and types for the DDC receive-path I/Q formatter.
//   IN_W_DEF / OUT_W_DEF : default DDC input width and I2S output width
//   HEAD_W               : headroom bits added before the gain shift (max shift 15)
//   ROUND_BIAS           : round-half-up bias at the default widths
//   SAT_MAX / SAT_MIN    : saturation limits at the default output width
//   iq_pair_t            : one formatted I/Q pair as stored in the FIFO
package rx_iq_pkg;

    localparam int unsigned IN_W_DEF  = 32;
    localparam int unsigned OUT_W_DEF = 24;
    localparam int unsigned GAIN_W    = 4;
    localparam int unsigned HEAD_W    = 16;
    localparam int unsigned DROP_W    = IN_W_DEF - OUT_W_DEF;

    localparam logic signed [IN_W_DEF+HEAD_W-1:0] ROUND_BIAS =
        (IN_W_DEF + HEAD_W)'(1) << (DROP_W - 1);
    localparam logic signed [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF - 1){1'b1}}};
    localparam logic signed [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF - 1){1'b0}}};

    typedef struct packed {
        logic [OUT_W_DEF-1:0] re;
        logic [OUT_W_DEF-1:0] im;
    } iq_pair_t;

endpackage

// File: rtl/rx_iq_fifo.sv
// rx_iq_fifo: single-clock synchronous FIFO for formatted I/Q pairs.
//   clock, reset      : system clock, asynchronous active-low reset
//   push / wdata      : write request and data; dropped when full unless popping
//   pop / rdata       : read request; rdata shows the head entry (show-ahead)
//   level             : occupancy 0..2**AW
//   full / empty      : derived from the extra pointer bit
module rx_iq_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned AW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             wr_en, rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign level = wptr_q - rptr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + (AW + 1)'(1);
            if (rd_en) rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rx_iq_formatter.sv
// rx_iq_formatter: gain, round, saturate and pace DDC I/Q samples for the I2S slave.
//   clock, reset          : system clock, asynchronous active-low reset
//   gain_shift            : left shift 0..15 applied before rounding
//   clr_flags             : pulse, clears overrun/underrun (a same-cycle event wins)
//   test_mode             : only with RX_TEST_PATTERN_EN; ticks load a ramp instead
//   in_valid/in_real/imag : DDC sample pair, no backpressure
//   out_real/out_imag     : held sample pair, changes at most once per PACE_DIV cycles
//   out_stb               : high for the cycle in which new out_* values appear
//   fifo_level            : buffered pair count
//   overrun / underrun    : sticky drop / empty-tick flags
// Optional feature macro: RX_TEST_PATTERN_EN.
module rx_iq_formatter
    import rx_iq_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned FIFO_AW  = 2,
    parameter int unsigned PACE_DIV = 2560
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [GAIN_W-1:0] gain_shift,
    input  logic              clr_flags,
`ifdef RX_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_real,
    input  logic [IN_W-1:0]   in_imag,
    output logic [OUT_W-1:0]  out_real,
    output logic [OUT_W-1:0]  out_imag,
    output logic              out_stb,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned EXT_W    = IN_W + HEAD_W;
    localparam int unsigned LSB_DROP = IN_W - OUT_W;
    localparam int unsigned CNT_W    = $clog2(PACE_DIV);

    localparam logic signed [EXT_W-1:0] RND    = EXT_W'(1) << (LSB_DROP - 1);
    localparam logic signed [EXT_W-1:0] SAT_HI = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

    function automatic logic [OUT_W-1:0] rnd_sat(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] q;
        q = v >>> LSB_DROP;
        if (q > SAT_HI)      return SAT_HI[OUT_W-1:0];
        else if (q < SAT_LO) return SAT_LO[OUT_W-1:0];
        else                 return q[OUT_W-1:0];
    endfunction

    // S1: sign-extend, shift, add rounding bias.
    logic signed [EXT_W-1:0] rnd_re, rnd_im;
    assign rnd_re = (EXT_W'(signed'(in_real)) <<< gain_shift) + RND;
    assign rnd_im = (EXT_W'(signed'(in_imag)) <<< gain_shift) + RND;

    logic                    s1_vld_q, s2_vld_q;
    logic signed [EXT_W-1:0] s1_re_q, s1_im_q;
    logic [2*OUT_W-1:0]      s2_pair_q, fifo_rdata;
    logic                    fifo_full, fifo_empty;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, pop, uf_evt, of_evt;
    logic [OUT_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic             stb_q, stb_d, overrun_q, overrun_d, underrun_q, underrun_d;
`ifdef RX_TEST_PATTERN_EN
    logic [OUT_W-1:0] ramp_q, ramp_d;
`endif

    rx_iq_fifo #(
        .WIDTH (2 * OUT_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (s2_vld_q),
        .wdata (s2_pair_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick  = (cnt_q == CNT_W'(PACE_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        pop        = tick && !fifo_empty;
        uf_evt     = tick && fifo_empty;
        of_evt     = s2_vld_q && fifo_full && !pop;
        out_re_d   = out_re_q;
        out_im_d   = out_im_q;
        stb_d      = 1'b0;
        if (pop) begin
            out_re_d = fifo_rdata[2*OUT_W-1:OUT_W];
            out_im_d = fifo_rdata[OUT_W-1:0];
            stb_d    = 1'b1;
        end
`ifdef RX_TEST_PATTERN_EN
        // Ramp overrides the popped data; the FIFO still drains on each tick.
        ramp_d = ramp_q;
        if (test_mode && tick) begin
            out_re_d = ramp_q;
            out_im_d = ~ramp_q;
            stb_d    = 1'b1;
            ramp_d   = ramp_q + OUT_W'(1);
            uf_evt   = 1'b0;
        end
`endif
        overrun_d  = of_evt || (overrun_q && !clr_flags);
        underrun_d = uf_evt || (underrun_q && !clr_flags);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_pair_q  <= '0;
            cnt_q      <= '0;
            out_re_q   <= '0;
            out_im_q   <= '0;
            stb_q      <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef RX_TEST_PATTERN_EN
            ramp_q     <= '0;
`endif
        end else begin
            s1_vld_q   <= in_valid;
            s1_re_q    <= rnd_re;
            s1_im_q    <= rnd_im;
            s2_vld_q   <= s1_vld_q;
            s2_pair_q  <= {rnd_sat(s1_re_q), rnd_sat(s1_im_q)};
            cnt_q      <= cnt_d;
            out_re_q   <= out_re_d;
            out_im_q   <= out_im_d;
            stb_q      <= stb_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
`ifdef RX_TEST_PATTERN_EN
            ramp_q     <= ramp_d;
`endif
        end
    end

    assign out_real = out_re_q;
    assign out_imag = out_im_q;
    assign out_stb  = stb_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_rx_iq_formatter.sv
// Directed bench for rx_iq_formatter with PACE_DIV=8, FIFO depth 4.
// Edge numbers in comments count clock rising edges after the first reset release.
module tb_rx_iq_formatter;

    logic        clock;
    logic        reset;
    logic [3:0]  gain_shift;
    logic        clr_flags;
`ifdef RX_TEST_PATTERN_EN
    logic        test_mode;
`endif
    logic        in_valid;
    logic [31:0] in_real, in_imag;
    logic [23:0] out_real, out_imag;
    logic        out_stb;
    logic [2:0]  fifo_level;
    logic        overrun, underrun;

    int total = 0;
    int bad   = 0;

    rx_iq_formatter #(
        .IN_W     (32),
        .OUT_W    (24),
        .FIFO_AW  (2),
        .PACE_DIV (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .gain_shift (gain_shift),
        .clr_flags  (clr_flags),
`ifdef RX_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_stb    (out_stb),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        gain_shift = 4'd0;
        clr_flags  = 1'b0;
`ifdef RX_TEST_PATTERN_EN
        test_mode  = 1'b0;
`endif
        in_valid   = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        cyc(3);
        chk("rst_out_real", 32'(out_real), 32'h0);
        chk("rst_out_imag", 32'(out_imag), 32'h0);
        chk("rst_stb", 32'(out_stb), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        reset = 1'b1;                                   // edge 0

        // Empty ticks: first tick at edge 8.
        cyc(7);
        chk("uf_before_tick", 32'(underrun), 32'h0);
        cyc(1);                                         // edge 8
        chk("uf_first_tick", 32'(underrun), 32'h1);
        chk("uf_no_stb", 32'(out_stb), 32'h0);
        chk("uf_out_real", 32'(out_real), 32'h0);
        clr_flags = 1'b1;
        cyc(1);                                         // edge 9
        clr_flags = 1'b0;
        chk("uf_cleared", 32'(underrun), 32'h0);
        cyc(6);                                         // edge 15
        clr_flags = 1'b1;
        cyc(1);                                         // edge 16, tick and clear together
        chk("uf_event_wins", 32'(underrun), 32'h1);
        cyc(1);                                         // edge 17, clr still high
        clr_flags = 1'b0;
        chk("uf_cleared2", 32'(underrun), 32'h0);

        // Rounding, gain 0: write at edge 20, pop at edge 24.
        in_valid = 1'b1;
        in_real  = 32'h0000_1280;
        in_imag  = 32'hFFFF_FE80;
        cyc(1);                                         // edge 18
        in_valid = 1'b0;
        cyc(1);                                         // edge 19
        chk("lat_level0", 32'(fifo_level), 32'h0);
        cyc(1);                                         // edge 20
        chk("lat_level1", 32'(fifo_level), 32'h1);
        cyc(3);                                         // edge 23
        chk("pre_tick_stb", 32'(out_stb), 32'h0);
        cyc(1);                                         // edge 24
        chk("t1_real", 32'(out_real), 32'h13);
        chk("t1_imag", 32'(out_imag), 32'hFFFFFF);
        chk("t1_stb", 32'(out_stb), 32'h1);
        chk("t1_level", 32'(fifo_level), 32'h0);
        chk("t1_underrun", 32'(underrun), 32'h0);
        cyc(1);                                         // edge 25
        chk("t1_stb_pulse", 32'(out_stb), 32'h0);

        // Saturation, gain 1: pop at edge 32.
        gain_shift = 4'd1;
        in_valid   = 1'b1;
        in_real    = 32'h4000_0000;
        in_imag    = 32'h8000_0000;
        cyc(1);                                         // edge 26
        in_valid = 1'b0;
        cyc(6);                                         // edge 32
        chk("t2_sat_hi", 32'(out_real), 32'h7FFFFF);
        chk("t2_sat_lo", 32'(out_imag), 32'h800000);
        chk("t2_stb", 32'(out_stb), 32'h1);
        gain_shift = 4'd0;

        // Sample k enters at edge 32+k and reaches the FIFO at edge 34+k.
        // Kept: 1..4 (edges 35..38), 6 (pop at 40), 14 (pop at 48).
        for (int k = 1; k <= 20; k++) begin
            in_valid = 1'b1;
            in_real  = 32'(k) << 8;
            in_imag  = -(32'(k) << 8);
            cyc(1);
            if (k == 6) begin
                chk("of_full_level", 32'(fifo_level), 32'h4);
                chk("of_not_yet", 32'(overrun), 32'h0);
            end
            if (k == 7) chk("of_set", 32'(overrun), 32'h1);
            if (k == 8) begin
                chk("of_pop1_real", 32'(out_real), 32'h1);
                chk("of_pop1_imag", 32'(out_imag), 32'hFFFFFF);
                chk("of_pushpop_level", 32'(fifo_level), 32'h4);
            end
            if (k == 16) chk("of_pop2_real", 32'(out_real), 32'h2);
        end
        in_valid = 1'b0;                                // edge 52
        cyc(4);                                         // edge 56
        chk("of_pop3_imag", 32'(out_imag), 32'hFFFFFD);
        chk("of_pop3_level", 32'(fifo_level), 32'h3);
        cyc(8);                                         // edge 64
        chk("of_pop4_real", 32'(out_real), 32'h4);
        cyc(8);                                         // edge 72
        chk("of_pop5_real", 32'(out_real), 32'h6);
        chk("of_pop5_imag", 32'(out_imag), 32'hFFFFFA);
        cyc(8);                                         // edge 80
        chk("of_pop6_real", 32'(out_real), 32'hE);
        chk("of_pop6_imag", 32'(out_imag), 32'hFFFFF2);
        chk("of_no_underrun", 32'(underrun), 32'h0);
        cyc(8);                                         // edge 88
        chk("drain_underrun", 32'(underrun), 32'h1);
        chk("drain_hold", 32'(out_real), 32'hE);
        chk("drain_no_stb", 32'(out_stb), 32'h0);

        // Reset with three pairs buffered (writes at edges 91..93).
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_real  = 32'h0000_2100 + (32'(k) << 8);
            in_imag  = 32'h0000_0500;
            cyc(1);
        end
        in_valid = 1'b0;                                // edge 91
        cyc(2);                                         // edge 93
        chk("mid_level3", 32'(fifo_level), 32'h3);
        chk("mid_overrun", 32'(overrun), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_level", 32'(fifo_level), 32'h0);
        chk("mid_rst_real", 32'(out_real), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        chk("mid_rst_underrun", 32'(underrun), 32'h0);
        cyc(2);
        reset = 1'b1;
        cyc(7);
        chk("rel_before_tick", 32'(underrun), 32'h0);
        cyc(1);
        chk("rel_underrun", 32'(underrun), 32'h1);
        chk("rel_no_stb", 32'(out_stb), 32'h0);
        chk("rel_out_real", 32'(out_real), 32'h0);

`ifdef RX_TEST_PATTERN_EN
        reset = 1'b0;
        cyc(1);
        test_mode = 1'b1;
        reset     = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(8);
            chk("tp_real", 32'(out_real), 32'(t));
            chk("tp_imag", 32'(out_imag), 32'h00FF_FFFF - 32'(t));
            chk("tp_underrun", 32'(underrun), 32'h0);
        end
        test_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
